// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT output frames into natural-order bursts with bin index and last marker.
module fft_bitrev_reorder #(
  parameter int N = 1024,
  parameter int DW = 25,
  localparam int AW = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] x_re_i,
  input  logic signed [DW-1:0] x_im_i,
  output logic                 valid_o,
  output logic signed [DW-1:0] z_re_o,
  output logic signed [DW-1:0] z_im_o,
  output logic [AW-1:0]        idx_o,
  output logic                 last_o
);
  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("fft_bitrev_reorder: N must be a power of two >= 4");
  end
  typedef enum logic {IDLE, READ} state_t;
  state_t          state_q;
  logic [2*DW-1:0] mem_q [2*N];
  logic [2*DW-1:0] rd_data_q;
  logic [AW-1:0]   wr_cnt_q, rd_cnt_q, idx1_q, wr_addr;
  logic            wr_bank_q, rd_bank_q, v1_q, frame_done;
  always_comb begin
    for (int i = 0; i < AW; i++) wr_addr[i] = wr_cnt_q[AW-1-i];
  end
  assign frame_done = valid_i && wr_cnt_q == AW'(N - 1);
  // Bank bit on top of the address: one array holds both ping-pong halves.
  always_ff @(posedge clk_i) begin
    if (valid_i) mem_q[{wr_bank_q, wr_addr}] <= {x_re_i, x_im_i};
    rd_data_q <= mem_q[{rd_bank_q, rd_cnt_q}];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      state_q   <= IDLE;
      v1_q      <= 1'b0;
      idx1_q    <= '0;
      valid_o   <= 1'b0;
      idx_o     <= '0;
      last_o    <= 1'b0;
      z_re_o    <= '0;
      z_im_o    <= '0;
    end else begin
      if (valid_i) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (frame_done) begin
        wr_bank_q <= ~wr_bank_q;
        state_q   <= READ;
        rd_cnt_q  <= '0;
        rd_bank_q <= wr_bank_q;
      end else if (state_q == READ) begin
        if (rd_cnt_q == AW'(N - 1)) state_q <= IDLE;
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      // Issue stage tracks the registered memory read; output stage follows.
      v1_q    <= state_q == READ;
      idx1_q  <= rd_cnt_q;
      valid_o <= v1_q;
      idx_o   <= idx1_q;
      last_o  <= v1_q && idx1_q == AW'(N - 1);
      if (v1_q) {z_re_o, z_im_o} <= rd_data_q;
    end
  end
endmodule
